// File: rtl/arith_seq_pkg.sv
// Shared types and sizing helpers for the block-serial arithmetic units.
package arith_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } sub_state_t;

    function automatic int block_count(input int data_width, input int block_width);
        return data_width / block_width;
    endfunction

    // A single-block datapath still needs a 1-bit counter.
    function automatic int count_width(input int n_blocks);
        return (n_blocks > 1) ? $clog2(n_blocks) : 1;
    endfunction

endpackage

// File: rtl/borrow_skip_block.sv
// One BLOCK_WIDTH slice of a subtractor: rippled borrow plus a skip path
// taken when every bit pair is equal, so the slice just passes borrow-in.
module borrow_skip_block #(
    parameter int BLOCK_WIDTH = 4
) (
    input  logic [BLOCK_WIDTH-1:0] a,
    input  logic [BLOCK_WIDTH-1:0] b,
    input  logic                   borrow_in,
    output logic [BLOCK_WIDTH-1:0] diff,
    output logic                   borrow_out
);

    logic [BLOCK_WIDTH:0] chain;
    logic                 propagate;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        chain    = '0;
        diff     = '0;
        chain[0] = borrow_in;
        for (int j = 0; j < BLOCK_WIDTH; j++) begin
            diff[j]      = a[j] ^ b[j] ^ chain[j];
            chain[j + 1] = (~a[j] & b[j]) | (~(a[j] ^ b[j]) & chain[j]);
        end
    end

    assign propagate  = &(~(a ^ b));
    assign borrow_out = propagate ? borrow_in : chain[BLOCK_WIDTH];

endmodule

// File: rtl/borrow_skip_subtractor_seq.sv
// Block-serial A - B - borrow_i: one borrow-skip slice per clock, start/valid
// handshake, result and flags held until the next operation overwrites them.
module borrow_skip_subtractor_seq
    import arith_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  borrow_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  borrow_o,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic                  valid_o
);

    localparam int N_BLOCKS = block_count(DATA_WIDTH, BLOCK_WIDTH);
    localparam int CNT_W    = count_width(N_BLOCKS);
    localparam logic [CNT_W-1:0] LAST_BLOCK = CNT_W'(N_BLOCKS - 1);

    sub_state_t             state;
    logic [DATA_WIDTH-1:0]  a_reg;
    logic [DATA_WIDTH-1:0]  b_reg;
    logic                   borrow_reg;
    logic [CNT_W-1:0]       cnt;

    logic [BLOCK_WIDTH-1:0] a_slice;
    logic [BLOCK_WIDTH-1:0] b_slice;
    logic [BLOCK_WIDTH-1:0] slice_diff;
    logic                   slice_borrow;
    logic                   last_block;

    assign a_slice    = a_reg[int'(cnt) * BLOCK_WIDTH +: BLOCK_WIDTH];
    assign b_slice    = b_reg[int'(cnt) * BLOCK_WIDTH +: BLOCK_WIDTH];
    assign last_block = (cnt == LAST_BLOCK);

    borrow_skip_block #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_block (
        .a          (a_slice),
        .b          (b_slice),
        .borrow_in  (borrow_reg),
        .diff       (slice_diff),
        .borrow_out (slice_borrow)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: operand and result registers are cleared too, so an aborted operation leaves nothing behind.
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            result_o   <= '0;
            borrow_o   <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_reg      <= operand_A_i;
                        b_reg      <= operand_B_i;
                        borrow_reg <= borrow_i;
                        cnt        <= '0;
                        busy_o     <= 1'b1;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    result_o[int'(cnt) * BLOCK_WIDTH +: BLOCK_WIDTH] <= slice_diff;
                    borrow_reg <= slice_borrow;
                    if (last_block) begin
                        // Signs of A and B differ and the result sign disagrees with A.
                        borrow_o   <= slice_borrow;
                        overflow_o <= (a_reg[DATA_WIDTH-1] != b_reg[DATA_WIDTH-1]) &&
                                      (slice_diff[BLOCK_WIDTH-1] != a_reg[DATA_WIDTH-1]);
                        valid_o    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// Bench for borrow_skip_subtractor_seq: directed corner cases, handshake and
// reset scenarios, back-to-back issue and a random sweep against an arithmetic model.
module tb_borrow_skip_subtractor_seq;

    localparam int DW      = 32;
    localparam int BUDGET  = 40;
    localparam int N_SWEEP = 3000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          bin;
    logic [DW-1:0] result;
    logic          borrow;
    logic          overflow;
    logic          busy;
    logic          valid;

    int n_cmp;
    int n_bad;

    borrow_skip_subtractor_seq #(
        .DATA_WIDTH  (DW),
        .BLOCK_WIDTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .operand_A_i (op_a),
        .operand_B_i (op_b),
        .borrow_i    (bin),
        .result_o    (result),
        .borrow_o    (borrow),
        .overflow_o  (overflow),
        .busy_o      (busy),
        .valid_o     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: full-precision arithmetic, then read off {result, borrow, overflow}.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic c);
        longint ua, ub, ud, sd;
        logic   ov;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ud = ua - ub - longint'(c);
        sd = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {ud[DW-1:0], (ud < 0), ov};
    endfunction

    // Launch one operation and wait for valid; reports observed outputs, the
    // cycle of valid (edge of acceptance = cycle 0) and whether busy/valid framing held.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c,
                          output logic [DW+1:0] obs, output int cyc, output bit hs_ok);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; bin = c;
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; bin = 1'($urandom);
        cyc   = 1;
        hs_ok = 1'b1;
        while (!valid && cyc < BUDGET) begin
            if (!busy) hs_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        obs = {result, borrow, overflow};
        if (!busy) hs_ok = 1'b0;
        @(negedge clk);
        if (valid || busy) hs_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({result, borrow, overflow, busy, valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected 0", {result, borrow, overflow, busy, valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [DW-1:0] va [5] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
        logic [DW-1:0] vb [5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
        logic          vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [DW+1:0] ve [5] = '{{32'h0000_0002, 2'b00}, {32'hFFFF_FFFF, 2'b10},
                                  {32'h7FFF_FFFF, 2'b01}, {32'h8000_0000, 2'b11},
                                  {32'hFFFF_FFFF, 2'b10}};
        logic [DW+1:0] obs;
        int            cyc;
        bit            hs_ok;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], obs, cyc, hs_ok);
            n_cmp++;
            if (obs !== ve[i]) begin
                n_bad++;
                $display("FAIL directed_%0d result: got %h expected %h", i, obs, ve[i]);
            end
            n_cmp++;
            if (cyc !== 9) begin
                n_bad++;
                $display("FAIL directed_%0d latency: got %0d expected 9", i, cyc);
            end
            n_cmp++;
            if (hs_ok !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_%0d handshake: got %0b expected 1", i, hs_ok);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [DW+1:0] exp_v;
        int            cyc;
        int            extra;
        exp_v = model(32'd100, 32'd58, 1'b0);
        @(negedge clk);
        start = 1'b1; op_a = 32'd100; op_b = 32'd58; bin = 1'b0;
        cyc = 0;
        while (!valid && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 3);
            if (cyc == 3) begin
                op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; bin = 1'b1;
            end
        end
        n_cmp++;
        if (cyc !== 9 || {result, borrow, overflow} !== exp_v) begin
            n_bad++;
            $display("FAIL busy_ignore: got cyc=%0d %h expected cyc=9 %h", cyc, {result, borrow, overflow}, exp_v);
        end
        start = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL busy_no_queue: got %0d extra pulses expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW+1:0] obs;
        int            cyc;
        bit            hs_ok;
        int            pulses;
        @(negedge clk);
        start = 1'b1; op_a = 32'hFFFF_0000; op_b = 32'h0000_FFFF; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({result, borrow, overflow, busy, valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h expected 0", {result, borrow, overflow, busy, valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_valid: got %0d pulses expected 0", pulses);
        end
        run_op(32'h0000_1000, 32'h0000_0FFF, 1'b1, obs, cyc, hs_ok);
        n_cmp++;
        if (obs !== model(32'h0000_1000, 32'h0000_0FFF, 1'b1) || cyc !== 9 || !hs_ok) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got %h cyc=%0d expected %h cyc=9",
                     obs, cyc, model(32'h0000_1000, 32'h0000_0FFF, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] va [3];
        logic [DW-1:0] vb [3];
        logic          vc [3];
        int            p;
        for (int i = 0; i < 3; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b1; op_a = va[0]; op_b = vb[0]; bin = vc[0];
        p = 0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge clk);
            if (valid) begin
                if (p < 3) begin
                    n_cmp++;
                    if (cyc !== 9 + 10 * p || {result, borrow, overflow} !== model(va[p], vb[p], vc[p])) begin
                        n_bad++;
                        $display("FAIL back_to_back_%0d: got cyc=%0d %h expected cyc=%0d %h", p, cyc,
                                 {result, borrow, overflow}, 9 + 10 * p, model(va[p], vb[p], vc[p]));
                    end
                end
                p++;
            end
            if (cyc == 1 || cyc == 11) begin
                op_a = va[cyc / 10 + 1]; op_b = vb[cyc / 10 + 1]; bin = vc[cyc / 10 + 1];
            end
            if (cyc == 21) start = 1'b0;
        end
        n_cmp++;
        if (p !== 3) begin
            n_bad++;
            $display("FAIL back_to_back_count: got %0d pulses expected 3", p);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b;
        logic          c;
        logic [DW+1:0] obs;
        int            cyc;
        bit            hs_ok;
        for (int i = 0; i < N_SWEEP; i++) begin
            a = $urandom; b = $urandom; c = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = '0;
                2: b = '1;
                3: a = {1'b1, 31'd0};
                default: ;
            endcase
            run_op(a, b, c, obs, cyc, hs_ok);
            n_cmp++;
            if (obs !== model(a, b, c) || cyc !== 9 || !hs_ok) begin
                n_bad++;
                $display("FAIL random_%0d a=%h b=%h c=%0b: got %h cyc=%0d hs=%0b expected %h cyc=9",
                         i, a, b, c, obs, cyc, hs_ok, model(a, b, c));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
